// File: rtl/max_search_2d.sv
// rtl/max_search_2d.sv - streaming N x N tile maximum search over a 50x20 8-bit image
//
// Purpose:
//   Holds a 1024 x 8 pixel buffer. With En low the host writes pixels through
//   D/WA. With En high the image is scanned as non-overlapping N x N tiles
//   (N = Pattern + 1) in raster order, one pixel per clock, and every
//   completed tile reports its maximum, the in-tile position of that maximum
//   and the tile coordinates.
//
// Ports:
//   Clk         in   clock, rising edge
//   Reset       in   asynchronous active-high reset
//   En          in   0 = load mode, 1 = scan mode
//   Pattern     in   tile size select, N = Pattern + 1
//   D, WA       in   write data / write address (load mode only)
//   MaxValue    out  maximum pixel value of the completed tile
//   MaxXPos     out  column offset of the maximum inside the tile
//   MaxYPos     out  row offset of the maximum inside the tile
//   MaxValid    out  one-cycle pulse qualifying the result outputs
//   XIndex_out  out  tile column index of the result
//   YIndex_out  out  tile row index of the result
//
// Configuration:
//   MAX_SEARCH_2D_TIE_LAST_EN  defined: ties resolve to the last equal pixel
//                              undefined: ties resolve to the first pixel

module max_search_2d (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       En,
  input  logic [1:0] Pattern,
  input  logic [7:0] D,
  input  logic [9:0] WA,
  output logic [7:0] MaxValue,
  output logic [1:0] MaxXPos,
  output logic [1:0] MaxYPos,
  output logic       MaxValid,
  output logic [6:0] XIndex_out,
  output logic [5:0] YIndex_out
);

  localparam logic [7:0] IMG_W = 8'd50;
  localparam logic [5:0] IMG_H = 6'd20;

  logic [7:0] mem [0:1023];

  // Scan state
  logic       running;   // high once the first scan edge after En rose has passed
  logic [1:0] pat_q;     // latched tile size select
  logic [6:0] tx;
  logic [5:0] ty;
  logic [1:0] cx;
  logic [1:0] cy;
  logic [7:0] acc_val;
  logic [1:0] acc_x;
  logic [1:0] acc_y;

  // Datapath
  logic [1:0] pat_eff;
  logic [2:0] n_eff;
  logic [7:0] x_pos;
  logic [5:0] y_pos;
  logic       in_image;
  logic [9:0] rd_addr;
  logic [7:0] pix;
  logic       first_px;
  logic       last_cx;
  logic       last_cy;
  logic       last_px;
  logic       take;
  logic [6:0] tx_last;
  logic [5:0] ty_last;
  logic [7:0] best_val;
  logic [1:0] best_x;
  logic [1:0] best_y;

  // The first scan edge already examines pixel 0, so it must use the
  // incoming Pattern directly rather than the not-yet-latched copy.
  assign pat_eff = running ? pat_q : Pattern;
  assign n_eff   = {1'b0, pat_eff} + 3'd1;

  assign x_pos    = ({1'b0, tx} * {5'd0, n_eff}) + {6'd0, cx};
  assign y_pos    = (ty * {3'd0, n_eff}) + {4'd0, cy};
  assign in_image = (x_pos < IMG_W) && (y_pos < IMG_H);
  assign rd_addr  = ({4'd0, y_pos} * 10'd50) + {2'd0, x_pos};
  // Out-of-image positions would otherwise alias into the next row.
  assign pix      = in_image ? mem[rd_addr] : 8'd0;

  assign first_px = (cx == 2'd0) && (cy == 2'd0);
  assign last_cx  = (cx == pat_eff);
  assign last_cy  = (cy == pat_eff);
  assign last_px  = last_cx && last_cy;

`ifdef MAX_SEARCH_2D_TIE_LAST_EN
  assign take = first_px || (pix >= acc_val);
`else
  assign take = first_px || (pix > acc_val);
`endif

  assign best_val = take ? pix : acc_val;
  assign best_x   = take ? cx  : acc_x;
  assign best_y   = take ? cy  : acc_y;

  // Last tile index per axis: ceil(50/N) - 1 and ceil(20/N) - 1.
  always_comb begin
    tx_last = 7'd49;
    ty_last = 6'd19;
    case (pat_eff)
      2'd0: begin tx_last = 7'd49; ty_last = 6'd19; end
      2'd1: begin tx_last = 7'd24; ty_last = 6'd9;  end
      2'd2: begin tx_last = 7'd16; ty_last = 6'd6;  end
      2'd3: begin tx_last = 7'd12; ty_last = 6'd4;  end
      default: begin tx_last = 7'd49; ty_last = 6'd19; end
    endcase
  end

  // Pixel buffer: write-only in load mode, not reset.
  always_ff @(posedge Clk) begin
    if (!En) begin
      mem[WA] <= D;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      running    <= 1'b0;
      pat_q      <= 2'd0;
      tx         <= 7'd0;
      ty         <= 6'd0;
      cx         <= 2'd0;
      cy         <= 2'd0;
      acc_val    <= 8'd0;
      acc_x      <= 2'd0;
      acc_y      <= 2'd0;
      MaxValue   <= 8'd0;
      MaxXPos    <= 2'd0;
      MaxYPos    <= 2'd0;
      MaxValid   <= 1'b0;
      XIndex_out <= 7'd0;
      YIndex_out <= 6'd0;
    end else if (!En) begin
      // Abort: restart from tile (0,0); result outputs keep their values.
      running  <= 1'b0;
      tx       <= 7'd0;
      ty       <= 6'd0;
      cx       <= 2'd0;
      cy       <= 2'd0;
      acc_val  <= 8'd0;
      acc_x    <= 2'd0;
      acc_y    <= 2'd0;
      MaxValid <= 1'b0;
    end else begin
      running <= 1'b1;
      if (!running) begin
        pat_q <= Pattern;
      end

      acc_val <= best_val;
      acc_x   <= best_x;
      acc_y   <= best_y;

      if (last_px) begin
        MaxValue   <= best_val;
        MaxXPos    <= best_x;
        MaxYPos    <= best_y;
        XIndex_out <= tx;
        YIndex_out <= ty;
        MaxValid   <= 1'b1;
      end else begin
        MaxValid <= 1'b0;
      end

      if (last_cx) begin
        cx <= 2'd0;
        if (last_cy) begin
          cy <= 2'd0;
          if (tx == tx_last) begin
            tx <= 7'd0;
            ty <= (ty == ty_last) ? 6'd0 : ty + 6'd1;
          end else begin
            tx <= tx + 7'd1;
          end
        end else begin
          cy <= cy + 2'd1;
        end
      end else begin
        cx <= cx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_max_search_2d.sv
// tb/tb_max_search_2d.sv - scoreboard bench for max_search_2d

module tb_max_search_2d;

  logic       Clk;
  logic       Reset;
  logic       En;
  logic [1:0] Pattern;
  logic [7:0] D;
  logic [9:0] WA;
  logic [7:0] MaxValue;
  logic [1:0] MaxXPos;
  logic [1:0] MaxYPos;
  logic       MaxValid;
  logic [6:0] XIndex_out;
  logic [5:0] YIndex_out;

  max_search_2d dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .En         (En),
    .Pattern    (Pattern),
    .D          (D),
    .WA         (WA),
    .MaxValue   (MaxValue),
    .MaxXPos    (MaxXPos),
    .MaxYPos    (MaxYPos),
    .MaxValid   (MaxValid),
    .XIndex_out (XIndex_out),
    .YIndex_out (YIndex_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

`ifdef MAX_SEARCH_2D_TIE_LAST_EN
  localparam bit TIE_LAST = 1'b1;
`else
  localparam bit TIE_LAST = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] v;
    logic [1:0] x;
    logic [1:0] y;
    logic [6:0] tx;
    logic [5:0] ty;
  } res_t;

  res_t sb[$];
  res_t mon_exp;
  res_t mon_act;
  int   vectors = 0;
  int   miscompares = 0;
  int   pulse_no = 0;

  logic [7:0] row0 [12] = '{8'd13, 8'd23, 8'd34, 8'd17, 8'd36, 8'd39, 8'd123, 8'd243, 8'd134, 8'd117, 8'd236, 8'd239};
  logic [7:0] row1 [12] = '{8'd32, 8'd37, 8'd46, 8'd65, 8'd78, 8'd91, 8'd223, 8'd173, 8'd144, 8'd107, 8'd216, 8'd209};
  logic [7:0] row2 [12] = '{8'd21, 8'd22, 8'd55, 8'd78, 8'd98, 8'd93, 8'd221, 8'd229, 8'd155, 8'd178, 8'd198, 8'd153};

  // Monitor: every MaxValid pulse is matched against the head of the scoreboard.
  always @(negedge Clk) begin
    if (MaxValid === 1'b1) begin
      pulse_no++;
      vectors++;
      mon_act = '{MaxValue, MaxXPos, MaxYPos, XIndex_out, YIndex_out};
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL pulse%0d unexpected: got v=%0d pos=(%0d,%0d) tile=(%0d,%0d), want no pulse",
                 pulse_no, MaxValue, MaxXPos, MaxYPos, XIndex_out, YIndex_out);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_act !== mon_exp) begin
          miscompares++;
          $display("FAIL pulse%0d: got v=%0d pos=(%0d,%0d) tile=(%0d,%0d), want v=%0d pos=(%0d,%0d) tile=(%0d,%0d)",
                   pulse_no, mon_act.v, mon_act.x, mon_act.y, mon_act.tx, mon_act.ty,
                   mon_exp.v, mon_exp.x, mon_exp.y, mon_exp.tx, mon_exp.ty);
        end
      end
    end
  end

  task automatic push(input int v, input int x, input int y, input int tx, input int ty);
    res_t e;
    e.v  = v[7:0];
    e.x  = x[1:0];
    e.y  = y[1:0];
    e.tx = tx[6:0];
    e.ty = ty[5:0];
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic drained(input string name);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s: got %0d results still pending, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_outputs(input string name, input int v, input int x, input int y,
                             input int tx, input int ty, input int valid);
    chk({name, ".MaxValue"},   int'(MaxValue),   v);
    chk({name, ".MaxXPos"},    int'(MaxXPos),    x);
    chk({name, ".MaxYPos"},    int'(MaxYPos),    y);
    chk({name, ".XIndex_out"}, int'(XIndex_out), tx);
    chk({name, ".YIndex_out"}, int'(YIndex_out), ty);
    chk({name, ".MaxValid"},   int'(MaxValid),   valid);
  endtask

  task automatic wr(input int addr, input logic [7:0] data);
    WA = addr[9:0];
    D  = data;
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 1024; a++) wr(a, 8'd0);
  endtask

  // Scan for a fixed number of edges, then drop En for one edge.
  task automatic run_scan(input logic [1:0] pat, input int cycles);
    Pattern = pat;
    En = 1'b1;
    repeat (cycles) @(posedge Clk);
    #1;
    En = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    En = 1'b0;
    Pattern = 2'd0;
    D = 8'd0;
    WA = 10'd0;
    @(posedge Clk);
    #2;
    chk_outputs("init_reset", 0, 0, 0, 0, 0, 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    clear_mem();
    for (int i = 0; i < 12; i++) begin
      wr(i, row0[i]);
      wr(50 + i, row1[i]);
      wr(100 + i, row2[i]);
    end

    // Abort mid-tile: no pulse may appear.
    run_scan(2'd2, 5);
    drained("abort_no_pulse");

    // 3x3 scan restarting from tile (0,0).
    push(55, 2, 2, 0, 0);
    push(98, 1, 2, 1, 0);
    push(243, 1, 0, 2, 0);
    push(239, 2, 0, 3, 0);
    run_scan(2'd2, 36);
    drained("scan3x3");
    chk_outputs("hold_after_abort", 239, 2, 0, 3, 0, 0);

    // Asynchronous reset mid-scan, then 1x1 scan from tile (0,0).
    Pattern = 2'd2;
    En = 1'b1;
    repeat (4) @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    chk_outputs("async_reset", 0, 0, 0, 0, 0, 0);
    Pattern = 2'd0;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) push(row0[i], 0, 0, i, 0);
    repeat (5) @(posedge Clk);
    #1;
    En = 1'b0;
    @(posedge Clk);
    #1;
    drained("scan1x1");

    // 4x4 along row 0, including the partial right-edge tile.
    for (int r = 0; r < 4; r++) begin
      wr(50 * r + 48, 8'd5);
      wr(50 * r + 49, (r == 2) ? 8'd9 : 8'd3);
    end
    push(78, 3, 2, 0, 0);
    push(243, 3, 0, 1, 0);
    push(239, 3, 0, 2, 0);
    for (int t = 3; t < 12; t++) push(0, TIE_LAST ? 3 : 0, TIE_LAST ? 3 : 0, t, 0);
    push(9, 1, 2, 12, 0);
    run_scan(2'd3, 13 * 16);
    drained("scan4x4_edge");

    // Ties: 2x2 tile of equal pixels.
    wr(0, 8'd77);
    wr(1, 8'd77);
    wr(50, 8'd77);
    wr(51, 8'd77);
    push(77, TIE_LAST ? 1 : 0, TIE_LAST ? 1 : 0, 0, 0);
    push(65, 1, 1, 1, 0);
    run_scan(2'd1, 8);
    drained("ties2x2");

    // Full 2x2 frame plus the wrap back to tile (0,0).
    clear_mem();
    wr(999, 8'd200);
    wr(0, 8'd99);
    for (int ty = 0; ty < 10; ty++) begin
      for (int tx = 0; tx < 25; tx++) begin
        if (tx == 0 && ty == 0)       push(99, 0, 0, 0, 0);
        else if (tx == 24 && ty == 9) push(200, 1, 1, 24, 9);
        else                          push(0, TIE_LAST ? 1 : 0, TIE_LAST ? 1 : 0, tx, ty);
      end
    end
    push(99, 0, 0, 0, 0);
    run_scan(2'd1, 251 * 4);
    drained("wrap2x2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/max_search_2d.md
# max_search_2d

Streaming 2-D window-maximum engine for an 8-bit image held in an internal 1024×8 pixel buffer. While `En` is low, a host loads pixels through a write port. While `En` is high, the block scans the image as non-overlapping N×N tiles in raster order, one pixel per clock. For each tile it reports the maximum value, that value's position inside the tile, and the tile coordinates. It sits between the frame loader and the peak-detection post-processing stage.

## Interface
- No parameters. Image geometry is fixed: width 50, height 20, linear address = 50·y + x.
- `Clk` in 1: sole clock, rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `En` in 1: 0 = load mode, 1 = scan mode.
- `Pattern` in 2: tile size select, N = Pattern + 1 (1×1 … 4×4).
- `D` in 8: write pixel data.
- `WA` in 10: write address.
- `MaxValue` out 8: maximum pixel value of the completed tile.
- `MaxXPos` out 2: column offset (0..N−1) of the maximum within the tile.
- `MaxYPos` out 2: row offset (0..N−1) of the maximum within the tile.
- `MaxValid` out 1: one-cycle pulse; the result outputs are valid while it is high.
- `XIndex_out` out 7: tile column index of the reported result.
- `YIndex_out` out 6: tile row index of the reported result.

## Operation
- **Buffer**
  - When `En`=0, each rising edge writes `D` to `mem[WA]`. All 1024 entries are writable; 1000–1023 are never scanned.
  - Buffer contents are not reset.
  - Combinational read, so a pixel can be written and then scanned on later cycles.
- **Pattern latch**
  - `Pattern` is latched on the first scan edge after `En` rises. It is ignored at all other times.
- **Scan counters**
  - Tile indices (tx, ty) and in-tile offsets (cx, cy).
  - Pixel examined = (x = tx·N + cx, y = ty·N + cy).
  - cx increments first, then cy. Then tx advances to the next tile; after the last tile column, tx returns to 0 and ty increments.
  - Tiles per row = ceil(50/N); tile rows = ceil(20/N). For N=1/2/3/4 these are 50×20, 25×10, 17×7, 13×5.
  - After the bottom-right tile, scanning wraps to tile (0,0) and continues while `En`=1.
- **Edge pixels**
  - Positions with x ≥ 50 or y ≥ 20 read as value 0.
- **Compare**
  - The first pixel of a tile loads the accumulator: value plus (cx, cy).
  - Each later pixel replaces the accumulator only if strictly greater, so on ties the first pixel in raster order wins.
- **Result**
  - On the edge that examines a tile's last pixel (cx = cy = N−1), the final max and position are registered to the outputs together with tx/ty, and `MaxValid` is set.
  - `MaxValid` clears on the next edge unless that edge also completes a tile (always the case for N=1).
- **Pausing scan**
  - `En` falling aborts the scan: counters go to tile (0,0), offsets to 0, the accumulator is discarded, and `MaxValid` goes to 0.
  - Result outputs hold their last values.
- **Reset**
  - All counters, the accumulator and the latched N are cleared (latched N = 1).
  - Outputs go to `MaxValue`=0, positions 0, indices 0, `MaxValid`=0.
  - Reset mid-scan restarts at tile (0,0) once `En` is sampled high after release.

## Timing
- One pixel per cycle; no stall; no gaps between tiles.
- Results update every N² cycles.
- First result: `MaxValid` goes high after the N²-th rising edge with `En`=1, and stays high for one cycle.
- Writes issued while `En`=0 are visible to a scan starting on the very next edge.

## Configuration
- Macro `MAX_SEARCH_2D_TIE_LAST_EN`.
  - Defined: the compare is greater-or-equal, so on ties the last equal pixel in raster order wins.
  - Undefined (default): strictly-greater compare, first pixel wins.

## Test plan
- **Reset:** pulse `Reset` mid-run → all outputs 0 immediately (asynchronous), scan restarts at tile (0,0).
- **3×3 scan** (`Pattern`=2):
  - Load row 0 cols 0–11 = 13,23,34,17,36,39,123,243,134,117,236,239.
  - Load row 1 (WA 50–61) = 32,37,46,65,78,91,223,173,144,107,216,209.
  - Load row 2 (WA 100–111) = 21,22,55,78,98,93,221,229,155,178,198,153.
  - Raise `En`. Expected pulses every 9 cycles:
    - (X0,Y0) → 55, pos (2,2)
    - (X1,Y0) → 98, pos (1,2)
    - (X2,Y0) → 243, pos (1,0)
    - (X3,Y0) → 239, pos (2,0)
- **1×1** (`Pattern`=0): `MaxValid` continuously high; `MaxValue` follows pixels 13, 23, 34 …; `XIndex_out` counts 0,1,2 …; positions always 0.
- **Ties:** 2×2 tile all 77 → pos (0,0); with macro defined → pos (1,1).
- **Edge tile:** 4×4 tile X12 (cols 48–51) with cols 48–49 = 5 and 9 → 9 at pos (1,y); out-of-image pixels do not win.
- **Abort/wrap:** drop `En` mid-tile → no pulse, restart at (0,0) on re-enable. Full 2×2 scan → after tile (24,9), the next tile is (0,0).
